ring_fx_sequencer: RTL and testbench
====================================

Name: ring_fx_sequencer

Overview:
Frame-rate controller that sequences the concentric-rings pixel datapath.
- Owns the ring animation phase and drives a ready-to-add signed offset, so the datapath needs no frame counter of its own.
- Runs an autoplay schedule: sweep outward, hold, sweep inward, hold. It can be overridden manually from the ui_in controls.
- Sits between the ui_in pins / hvsync_generator and the ring colour logic. All outputs change only at frame boundaries, so there is no tearing.

Parameters:
SWEEP_FRAMES, 240, frames spent in each sweep state (minimum 1)
HOLD_FRAMES, 60, frames spent in each hold state (minimum 1)
STEP_SLOW, 1, phase step per frame when speed=0 (range 0..127)
STEP_FAST, 2, phase step per frame when speed=1 (range 0..127)

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, synchronous, active-low
frame_tick  in  1  one-cycle pulse at hpos==0 && vpos==0
auto_en  in  1  asynchronous pin; 1 = autoplay schedule, 0 = manual
manual_dir  in  1  asynchronous pin; manual direction, 0 = outward, 1 = inward
speed  in  1  asynchronous pin; 0 = STEP_SLOW, 1 = STEP_FAST
pause  in  1  asynchronous pin; 1 = freeze animation and schedule
ring_offset  out  8  phase added by the datapath to radius[7:0], mod 256
direction  out  1  current sweep direction, 0 = outward, 1 = inward
palette_sel  out  2  colour-mapping select for the datapath
fsm_state  out  2  debug view of the state register

Behaviour:
- Reset: rst_n sampled low at a clk edge clears all state on that edge.
  - ring_offset=0, direction=0, palette_sel=0, fsm_state=S_OUT, dwell counter=0, synchronizer flops=0.
  - Reset mid-frame is legal; the next frame_tick is treated as the first.
- Input synchronizers:
  - auto_en, manual_dir, speed and pause each pass through a 2-flop synchronizer.
  - A pin change must be stable for at least 2 clk before a frame_tick to be honoured at that tick.
- Update timing:
  - All state updates occur only on clk edges where frame_tick=1.
  - Outputs are registered and become valid on the cycle after the tick.
  - Between ticks, outputs hold constant.
- States (fsm_state encoding): S_OUT=0, S_HOLD_OUT=1, S_IN=2, S_HOLD_IN=3. direction=1 exactly in S_IN and S_HOLD_IN.
- Phase arithmetic, per tick, with step = speed ? STEP_FAST : STEP_SLOW:
  - S_OUT: ring_offset += step.
  - S_IN: ring_offset -= step.
  - Hold states: unchanged.
  - Arithmetic is 8-bit with wrap-around (255+1 gives 0; 0-1 gives 255).
  - The phase change applies on the tick that also causes a state exit.
- Dwell counter: width $clog2(max(SWEEP_FRAMES,HOLD_FRAMES))+1. It counts ticks spent in the current state. On a tick where dwell == limit-1, the state advances and dwell is set to 0; otherwise dwell increments.
- Autoplay order (auto_en=1): S_OUT -> S_HOLD_OUT -> S_IN -> S_HOLD_IN -> S_OUT.
  - On entry to either hold state, palette_sel increments (3 wraps to 0).
- Manual mode (auto_en=0), at each tick:
  - State becomes manual_dir ? S_IN : S_OUT; dwell is forced to 0; palette_sel holds.
  - The phase updates in the new state on that same tick.
  - A manual direction flip therefore reverses the motion without a jump in ring_offset.
- Re-entering autoplay (auto_en 0 -> 1 seen at a tick): the schedule resumes from the current sweep state with dwell=0.
- Pause:
  - A tick with pause=1 changes nothing: no phase step, dwell, state, palette or mode change.
  - Pause has priority over every other event at that tick.
- A frame_tick asserted in consecutive cycles is treated as independent ticks; there is no filtering.

Decomposition:
- Package ring_fx_pkg holds:
  - the state enum type ring_fx_state_t (S_OUT, S_HOLD_OUT, S_IN, S_HOLD_IN);
  - localparams for the default SWEEP_FRAMES, HOLD_FRAMES, STEP_SLOW and STEP_FAST.
- One sub-module, ring_fx_sync2: a parameterised-width 2-flop synchronizer with the same synchronous active-low rst_n. It is instantiated once, 4 bits wide.

Test Plan:
All scenarios use SWEEP_FRAMES=4, HOLD_FRAMES=2, STEP_SLOW=1, STEP_FAST=2 unless stated.
- Reset, auto_en=1, speed=0, 12 ticks -> ring_offset 1,2,3,4,4,4,3,2,1,0,0,0; fsm_state after ticks 4/6/10/12 = 1/2/3/0; palette_sel 1 after tick 4, 2 after tick 10; direction=1 after ticks 6-11.
- auto_en=0, manual_dir=0, speed=1, 3 ticks, then manual_dir=1, 2 ticks -> offset 2,4,6,4,2; palette_sel stays 0.
- Wrap-around: manual inward from reset, speed=0, 1 tick -> offset 255; then outward, 1 tick -> 0.
- pause=1 held across 5 ticks mid-S_IN (offset=3, dwell=1) -> all outputs unchanged; after release, next tick -> offset 2, dwell=2.
- Assert rst_n=0 for 1 clk between ticks while in S_HOLD_IN with palette_sel=2 -> next cycle all outputs 0 and fsm_state=0.
- Toggle speed 1 clk before a tick -> old step used at that tick; toggle 3 clk before -> new step used.

Source files
------------

// File: rtl/ring_fx_pkg.sv
// Shared types and default parameters for the concentric-rings frame sequencer.
package ring_fx_pkg;

  typedef enum logic [1:0] {
    S_OUT      = 2'd0,
    S_HOLD_OUT = 2'd1,
    S_IN       = 2'd2,
    S_HOLD_IN  = 2'd3
  } ring_fx_state_t;

  localparam int unsigned DEF_SWEEP_FRAMES = 240;
  localparam int unsigned DEF_HOLD_FRAMES  = 60;
  localparam int unsigned DEF_STEP_SLOW    = 1;
  localparam int unsigned DEF_STEP_FAST    = 2;

  // Autoplay order is a plain 2-bit increment through the encoding.
  function automatic ring_fx_state_t next_state(input ring_fx_state_t s);
    return ring_fx_state_t'(s + 2'd1);
  endfunction

endpackage

// File: rtl/ring_fx_sync2.sv
// Parameterised-width two-flop synchronizer with synchronous active-low reset.
module ring_fx_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/ring_fx_sequencer.sv
// Frame-rate controller for the rings datapath: owns the animation phase, the
// autoplay schedule and the palette select; all state moves only on frame_tick.
module ring_fx_sequencer
  import ring_fx_pkg::*;
#(
  parameter int unsigned SWEEP_FRAMES = DEF_SWEEP_FRAMES,
  parameter int unsigned HOLD_FRAMES  = DEF_HOLD_FRAMES,
  parameter int unsigned STEP_SLOW    = DEF_STEP_SLOW,
  parameter int unsigned STEP_FAST    = DEF_STEP_FAST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       auto_en,
  input  logic       manual_dir,
  input  logic       speed,
  input  logic       pause,
  output logic [7:0] ring_offset,
  output logic       direction,
  output logic [1:0] palette_sel,
  output logic [1:0] fsm_state
);

  localparam int unsigned MAX_FRAMES = (SWEEP_FRAMES > HOLD_FRAMES) ? SWEEP_FRAMES : HOLD_FRAMES;
  localparam int unsigned DW         = $clog2(MAX_FRAMES) + 1;

  localparam logic [DW-1:0] SWEEP_LAST = DW'(SWEEP_FRAMES - 1);
  localparam logic [DW-1:0] HOLD_LAST  = DW'(HOLD_FRAMES - 1);
  localparam logic [7:0]    STEP_S     = 8'(STEP_SLOW);
  localparam logic [7:0]    STEP_F     = 8'(STEP_FAST);

  logic [3:0] pins_s;
  logic       auto_s, dir_s, speed_s, pause_s;

  ring_fx_sync2 #(
    .WIDTH (4)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({auto_en, manual_dir, speed, pause}),
    .q     (pins_s)
  );

  assign {auto_s, dir_s, speed_s, pause_s} = pins_s;

  ring_fx_state_t state_q, state_d, motion_state;
  logic [DW-1:0]  dwell_q, dwell_d, dwell_last;
  logic [7:0]     offset_q, offset_d, step;
  logic [1:0]     palette_q, palette_d;

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    offset_d  = offset_q;
    palette_d = palette_q;
    step      = speed_s ? STEP_F : STEP_S;

    // Manual mode picks its sweep state first so a flip reverses without a jump.
    motion_state = state_q;
    if (!auto_s) begin
      motion_state = dir_s ? S_IN : S_OUT;
    end

    if (motion_state == S_OUT) begin
      offset_d = offset_q + step;
    end else if (motion_state == S_IN) begin
      offset_d = offset_q - step;
    end

    dwell_last = state_q[0] ? HOLD_LAST : SWEEP_LAST;

    if (!auto_s) begin
      state_d = motion_state;
      dwell_d = '0;
    end else if (dwell_q == dwell_last) begin
      state_d = next_state(state_q);
      dwell_d = '0;
      if (state_d == S_HOLD_OUT || state_d == S_HOLD_IN) begin
        palette_d = palette_q + 2'd1;
      end
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_OUT;
      dwell_q   <= '0;
      offset_q  <= '0;
      palette_q <= '0;
    end else if (frame_tick && !pause_s) begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      offset_q  <= offset_d;
      palette_q <= palette_d;
    end
  end

  assign ring_offset = offset_q;
  assign direction   = state_q[1];
  assign palette_sel = palette_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_ring_fx_sequencer.sv
// Bench for ring_fx_sequencer: directed tables, hand-written corner sequences and a
// randomized run against a schedule-level reference model.
module tb_ring_fx_sequencer;

  localparam int SWEEP = 4;
  localparam int HOLD  = 2;
  localparam int SLOW  = 1;
  localparam int FAST  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       auto_en = 1'b0;
  logic       manual_dir = 1'b0;
  logic       speed = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] ring_offset;
  logic       direction;
  logic [1:0] palette_sel;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_err    = 0;

  ring_fx_sequencer #(
    .SWEEP_FRAMES (SWEEP),
    .HOLD_FRAMES  (HOLD),
    .STEP_SLOW    (SLOW),
    .STEP_FAST    (FAST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .auto_en     (auto_en),
    .manual_dir  (manual_dir),
    .speed       (speed),
    .pause       (pause),
    .ring_offset (ring_offset),
    .direction   (direction),
    .palette_sel (palette_sel),
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  // Reference model: phase index 0..3 = out, hold-out, in, hold-in.
  int         m_state, m_phase, m_dwell, m_pal;
  logic [3:0] pin_hist1, pin_hist2;  // pins seen one and two edges ago
  int         lim_of[4] = '{SWEEP, HOLD, SWEEP, HOLD};
  int         sgn_of[4] = '{1, 0, -1, 0};

  task automatic model_edge(input logic tick, input logic rstn);
    logic [3:0] eff;
    int step;
    if (!rstn) begin
      m_state = 0; m_phase = 0; m_dwell = 0; m_pal = 0;
      pin_hist1 = '0; pin_hist2 = '0;
      return;
    end
    eff = pin_hist2;
    pin_hist2 = pin_hist1;
    pin_hist1 = {auto_en, manual_dir, speed, pause};
    if (!tick || eff[0]) return;
    step = eff[1] ? FAST : SLOW;
    if (!eff[3]) begin
      m_state = eff[2] ? 2 : 0;
      m_dwell = 0;
    end
    m_phase = (m_phase + 256 + sgn_of[m_state] * step) % 256;
    if (eff[3]) begin
      if (m_dwell == lim_of[m_state] - 1) begin
        m_dwell = 0;
        m_state = (m_state + 1) % 4;
        if (m_state % 2 == 1) m_pal = (m_pal + 1) % 4;
      end else begin
        m_dwell++;
      end
    end
  endtask

  task automatic cyc(input logic tick, input logic rstn = 1'b1);
    frame_tick = tick;
    rst_n      = rstn;
    @(posedge clk);
    model_edge(tick, rstn);
    #1;
    frame_tick = 1'b0;
    rst_n      = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic tk();
    cyc(1'b1);
    idle(3);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int off, input int st, input int pal,
                         input int dir);
    chk({nm, ".offset"}, int'(ring_offset), off);
    chk({nm, ".state"}, int'(fsm_state), st);
    chk({nm, ".palette"}, int'(palette_sel), pal);
    chk({nm, ".direction"}, int'(direction), dir);
  endtask

  task automatic chk_model(input string nm);
    chk_out(nm, m_phase, m_state, m_pal, (m_state >= 2) ? 1 : 0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0);
    idle(3);
  endtask

  typedef struct {
    int off;
    int st;
    int pal;
    int dir;
  } vec_t;

  vec_t auto_tbl[12];

  initial begin
    auto_tbl = '{
      '{1, 0, 0, 0}, '{2, 0, 0, 0}, '{3, 0, 0, 0}, '{4, 1, 1, 0},
      '{4, 1, 1, 0}, '{4, 2, 1, 1}, '{3, 2, 1, 1}, '{2, 2, 1, 1},
      '{1, 2, 1, 1}, '{0, 3, 2, 1}, '{0, 3, 2, 1}, '{0, 0, 2, 0}
    };

    // Reset state
    auto_en = 1'b1; manual_dir = 1'b0; speed = 1'b0; pause = 1'b0;
    cyc(1'b0, 1'b0);
    chk_out("reset", 0, 0, 0, 0);
    idle(3);

    // Autoplay schedule
    for (int i = 0; i < 12; i++) begin
      tk();
      chk_out($sformatf("auto_t%0d", i + 1), auto_tbl[i].off, auto_tbl[i].st,
              auto_tbl[i].pal, auto_tbl[i].dir);
    end

    // Manual fast outward then flip inward
    auto_en = 1'b0; manual_dir = 1'b0; speed = 1'b1;
    do_reset();
    tk(); chk_out("man_t1", 2, 0, 0, 0);
    tk(); chk_out("man_t2", 4, 0, 0, 0);
    tk(); chk_out("man_t3", 6, 0, 0, 0);
    manual_dir = 1'b1; idle(3);
    tk(); chk_out("man_t4", 4, 2, 0, 1);
    tk(); chk_out("man_t5", 2, 2, 0, 1);

    // Wrap-around both ways
    manual_dir = 1'b1; speed = 1'b0;
    do_reset();
    tk(); chk_out("wrap_down", 255, 2, 0, 1);
    manual_dir = 1'b0; idle(3);
    tk(); chk_out("wrap_up", 0, 0, 0, 0);

    // Pause mid-S_IN (offset 3, dwell 1)
    auto_en = 1'b1; speed = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) tk();
    chk_out("pre_pause", 3, 2, 1, 1);
    pause = 1'b1; idle(3);
    for (int i = 0; i < 5; i++) begin
      tk();
      chk_out($sformatf("paused_t%0d", i + 1), 3, 2, 1, 1);
    end
    pause = 1'b0; idle(3);
    tk(); chk_out("unpause_t1", 2, 2, 1, 1);
    tk(); chk_out("unpause_t2", 1, 2, 1, 1);
    tk(); chk_out("unpause_t3", 0, 3, 2, 1);

    // Reset between ticks while in S_HOLD_IN
    cyc(1'b0, 1'b0);
    chk_out("mid_reset", 0, 0, 0, 0);

    // Speed change latency through the synchronizer
    auto_en = 1'b0; manual_dir = 1'b0; speed = 1'b0;
    do_reset();
    speed = 1'b1;
    cyc(1'b1);
    chk_out("speed_1clk", 1, 0, 0, 0);
    idle(3);
    speed = 1'b0;
    idle(2);
    cyc(1'b1);
    chk_out("speed_3clk", 2, 0, 0, 0);

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        auto_en    = ($urandom_range(0, 4) != 0);
        manual_dir = 1'($urandom);
        speed      = 1'($urandom);
        pause      = ($urandom_range(0, 3) == 0);
      end
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 299) != 0);
      chk_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
